regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
// - Parametrised general-purpose register file for the SLC-3 datapath: 1 write port from the bus, 2 async read ports.
// - Adds a per-register pending-write scoreboard (busy bits) and registered NZP condition codes.
// - Sits between bus/ALU and control FSM; the control FSM uses busy flags to stall operand reads.
// PARAMETERS
// - DATA_W    16  register / bus width in bits
// - NUM_REGS  8   number of registers; power of 2, >= 2
// - ADDR_W    $clog2(NUM_REGS)  register index width (localparam, derived)
// PORTS
// - clk          in   1         single clock, rising edge
// - reset        in   1         asynchronous, active-high reset
// - dr           in   ADDR_W    destination register index for write
// - ld_reg       in   1         1 = write bus_in into reg[dr] at next rising edge
// - bus_in       in   DATA_W    write data from datapath bus
// - sr1, sr2     in   ADDR_W    read indices
// - sr1_out      out  DATA_W    reg[sr1], combinational
// - sr2_out      out  DATA_W    reg[sr2], combinational
// - issue_valid  in   1         1 = reserve issue_dr as pending destination
// - issue_dr     in   ADDR_W    register to mark busy
// - sr1_busy     out  1         busy[sr1], combinational
// - sr2_busy     out  1         busy[sr2], combinational
// - busy_vec     out  NUM_REGS  full scoreboard, bit i = reg i pending
// - ld_cc        in   1         1 = update NZP from bus_in at next edge
// - n, z, p      out  1 each    registered condition codes
// BEHAVIOUR
// - Reset (async, any time, incl. mid-write): all regs = 0, busy_vec = 0, {n,z,p} = 3'b010; takes effect immediately, outputs valid while reset high.
// - Write: rising edge with ld_reg=1 -> reg[dr] <= bus_in; visible on sr*_out the following cycle (1-cycle latency).
// - Scoreboard per edge, per reg i:
//   - set if issue_valid && issue_dr==i
//   - else clear if ld_reg && dr==i
//   - else hold
//   - Simultaneous issue + write to same reg: set wins (new pending writer).
// - Issue to already-busy reg: stays busy (no error, no counting); one write clears it.
// - Write to non-busy reg: allowed, busy stays 0.
// - Condition codes: on edge with ld_cc=1: n = bus_in[DATA_W-1]; z = (bus_in==0); p = !n && !z.
//   - Exactly one of n,z,p high at all times; ld_cc independent of ld_reg; hold when ld_cc=0.
// - Reads: pure mux, no reset dependence beyond register contents; sr1==sr2 legal, both outputs identical.
// - No out-of-range index exists (NUM_REGS power of 2).
// CONFIGURATION
// - Macro REGFILE_SB_BYPASS_EN:
//   - Defined: if ld_reg && sr1==dr, sr1_out = bus_in and sr1_busy = 0 same cycle (same for sr2).
//     Busy still forced 1 if same-cycle issue_valid && issue_dr==sr.
//   - Undefined: reads return stored value (old data) during write cycle; sr*_busy = busy_vec[sr*] as stored.
//   - busy_vec and n/z/p unaffected by the macro.
// TESTING
// - Reset, read all regs -> sr1_out/sr2_out = 0x0000, busy_vec = 0, nzp = 010.
// - ld_reg=1, dr=3, bus_in=0x1234; next cycle sr1=3 -> sr1_out = 0x1234, others still 0.
// - Same-cycle read of R3 during write of 0xBEEF (old 0x1234):
//   - BYPASS_EN: sr2_out = 0xBEEF.
//   - Else: 0x1234, then 0xBEEF next cycle.
// - issue_valid, issue_dr=5 -> busy_vec = 0x20.
//   - Later write dr=5 -> 0x00.
//   - Issue+write dr=5 same edge -> busy stays 0x20.
// - ld_cc with bus_in 0x8000 -> nzp=100; 0x0000 -> 010; 0x0001 -> 001; ld_cc=0 -> held.
// - Assert reset mid-write (R2 <= 0xAAAA, busy[2]=1) -> R2 = 0, busy_vec = 0, nzp = 010 immediately.

Source files
------------

// File: rtl/regfile_sb.sv
// SLC-3 register file: one bus write port, two async read ports, per-register busy scoreboard, NZP codes.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_SB_BYPASS_EN.

module regfile_sb_cell #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              set,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q,
    output logic              busy
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            busy <= 1'b0;
        end else begin
            if (we) q <= wdata;
            // A new issue outranks the retiring write: it names a fresh pending writer.
            if (set)     busy <= 1'b1;
            else if (we) busy <= 1'b0;
        end
    end
endmodule

module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   dr,
    input  logic                ld_reg,
    input  logic [DATA_W-1:0]   bus_in,
    input  logic [ADDR_W-1:0]   sr1,
    input  logic [ADDR_W-1:0]   sr2,
    output logic [DATA_W-1:0]   sr1_out,
    output logic [DATA_W-1:0]   sr2_out,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_dr,
    output logic                sr1_busy,
    output logic                sr2_busy,
    output logic [NUM_REGS-1:0] busy_vec,
    input  logic                ld_cc,
    output logic                n,
    output logic                z,
    output logic                p
);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        regfile_sb_cell #(.DATA_W(DATA_W)) u_cell (
            .clk   (clk),
            .reset (reset),
            .we    (ld_reg && (dr == ADDR_W'(i))),
            .set   (issue_valid && (issue_dr == ADDR_W'(i))),
            .wdata (bus_in),
            .q     (regs[i]),
            .busy  (busy_vec[i])
        );
    end

`ifdef REGFILE_SB_BYPASS_EN
    always_comb begin
        sr1_out  = regs[sr1];
        sr2_out  = regs[sr2];
        sr1_busy = busy_vec[sr1];
        sr2_busy = busy_vec[sr2];
        if (ld_reg && dr == sr1) begin
            sr1_out  = bus_in;
            sr1_busy = 1'b0;
        end
        if (ld_reg && dr == sr2) begin
            sr2_out  = bus_in;
            sr2_busy = 1'b0;
        end
        // A same-cycle issue still makes the operand pending, even when forwarded.
        if (issue_valid && issue_dr == sr1) sr1_busy = 1'b1;
        if (issue_valid && issue_dr == sr2) sr2_busy = 1'b1;
    end
`else
    always_comb begin
        sr1_out  = regs[sr1];
        sr2_out  = regs[sr2];
        sr1_busy = busy_vec[sr1];
        sr2_busy = busy_vec[sr2];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {n, z, p} <= 3'b010;
        end else if (ld_cc) begin
            n <= bus_in[DATA_W-1];
            z <= (bus_in == '0);
            p <= !bus_in[DATA_W-1] && (bus_in != '0);
        end
    end
endmodule
